// File: rtl/fc_dma_pkg.sv
// Shared types for the FC-stage DMA loader: FSM states, FC bank region codes
// and region-length helpers derived from the layer sizes.
package fc_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      RG_X  = 3'd0,
      RG_W1 = 3'd1,
      RG_B1 = 3'd2,
      RG_W2 = 3'd3,
      RG_B2 = 3'd4
   } region_e;

   function automatic int unsigned region_len(input region_e r,
                                              input int unsigned ip1,
                                              input int unsigned op1,
                                              input int unsigned ip2,
                                              input int unsigned op2);
      case (r)
         RG_X:    return ip1;
         RG_W1:   return op1 * ip1;
         RG_B1:   return op1;
         RG_W2:   return op2 * ip2;
         default: return op2;
      endcase
   endfunction

   function automatic region_e next_region(input region_e r);
      case (r)
         RG_X:    return RG_W1;
         RG_W1:   return RG_B1;
         RG_B1:   return RG_W2;
         RG_W2:   return RG_B2;
         default: return RG_X;
      endcase
   endfunction

endpackage

// File: rtl/fc_dma_addr_gen.sv
// Region/index walker and issued-word counter for the FC DMA loader.
// Steps once per granted read; flags the final index of a region and of the whole sequence.
module fc_dma_addr_gen
   import fc_dma_pkg::*;
#(
   parameter int unsigned IP_LAYER1_SIZE = 128,
   parameter int unsigned OP_LAYER1_SIZE = 84,
   parameter int unsigned IP_LAYER2_SIZE = 84,
   parameter int unsigned OP_LAYER2_SIZE = 10,
   parameter int unsigned ADDRESS_SIZE   = 16,
   parameter int unsigned IDX_W          = 13
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic                    advance_i,
   output region_e                 region_o,
   output logic [IDX_W-1:0]        index_o,
   output logic [ADDRESS_SIZE-1:0] issue_cnt_o,
   output logic                    last_word_o
);

   region_e                 region_q, region_d;
   logic [IDX_W-1:0]        index_q, index_d;
   logic [ADDRESS_SIZE-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]        last_idx;
   logic                    last_in_region;

   always_comb begin
      last_idx       = IDX_W'(region_len(region_q, IP_LAYER1_SIZE, OP_LAYER1_SIZE,
                                         IP_LAYER2_SIZE, OP_LAYER2_SIZE) - 1);
      last_in_region = (index_q == last_idx);
      last_word_o    = last_in_region && (region_q == RG_B2);

      region_d = region_q;
      index_d  = index_q;
      cnt_d    = cnt_q;
      if (clear_i) begin
         region_d = RG_X;
         index_d  = '0;
         cnt_d    = '0;
      end else if (advance_i) begin
         cnt_d = cnt_q + 1'b1;
         if (last_in_region) begin
            index_d  = '0;
            region_d = next_region(region_q);
         end else begin
            index_d = index_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         region_q <= RG_X;
         index_q  <= '0;
         cnt_q    <= '0;
      end else begin
         region_q <= region_d;
         index_q  <= index_d;
         cnt_q    <= cnt_d;
      end
   end

   assign region_o    = region_q;
   assign index_o     = index_q;
   assign issue_cnt_o = cnt_q;

endmodule

// File: rtl/fc_dma_loader.sv
// Streams X, W1, B1, W2, B2 from shared RAM into the FC register banks, then raises enFC.
// Optional `FC_DMA_ABORT_EN adds an abort input that drops an in-progress transfer.
module fc_dma_loader
   import fc_dma_pkg::*;
#(
   parameter int unsigned  WORD_SIZE      = 16,
   parameter int unsigned  ADDRESS_SIZE   = 16,
   parameter int unsigned  IP_LAYER1_SIZE = 128,
   parameter int unsigned  OP_LAYER1_SIZE = 84,
   parameter int unsigned  IP_LAYER2_SIZE = 84,
   parameter int unsigned  OP_LAYER2_SIZE = 10,
   localparam int unsigned IDX_W          = $clog2(OP_LAYER1_SIZE * IP_LAYER1_SIZE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_SIZE-1:0] base_addr,
`ifdef FC_DMA_ABORT_EN
   input  logic                    abort,
`endif
   output logic                    ram_rd_en,
   output logic [ADDRESS_SIZE-1:0] ram_addr,
   input  logic                    ram_gnt,
   input  logic [WORD_SIZE-1:0]    ram_rd_data,
   output logic                    wr_en,
   output logic [2:0]              wr_region,
   output logic [IDX_W-1:0]        wr_index,
   output logic [WORD_SIZE-1:0]    wr_data,
   output logic                    busy,
   output logic                    done,
   output logic                    enFC
);

   state_e                  state_q, state_d;
   logic [ADDRESS_SIZE-1:0] base_q, base_d;
   logic                    enfc_q, enfc_d;
   logic                    tag_vld_q;
   region_e                 tag_region_q;
   logic [IDX_W-1:0]        tag_index_q;

   region_e                 cur_region;
   logic [IDX_W-1:0]        cur_index;
   logic [ADDRESS_SIZE-1:0] issue_cnt;
   logic                    last_word;
   logic                    abort_s;
   logic                    start_acc;
   logic                    issue;

`ifdef FC_DMA_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // An aborting cycle issues nothing, so no write can trail the return to IDLE.
   assign start_acc = (state_q == ST_IDLE) && start;
   assign ram_rd_en = (state_q == ST_FETCH) && !abort_s;
   assign issue     = ram_rd_en && ram_gnt;

   fc_dma_addr_gen #(
      .IP_LAYER1_SIZE (IP_LAYER1_SIZE),
      .OP_LAYER1_SIZE (OP_LAYER1_SIZE),
      .IP_LAYER2_SIZE (IP_LAYER2_SIZE),
      .OP_LAYER2_SIZE (OP_LAYER2_SIZE),
      .ADDRESS_SIZE   (ADDRESS_SIZE),
      .IDX_W          (IDX_W)
   ) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (start_acc),
      .advance_i   (issue),
      .region_o    (cur_region),
      .index_o     (cur_index),
      .issue_cnt_o (issue_cnt),
      .last_word_o (last_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: if (issue && last_word) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort_s && ((state_q == ST_FETCH) || (state_q == ST_DRAIN))) begin
         state_d = ST_IDLE;
      end

      enfc_d = enfc_q;
      if (start_acc) begin
         enfc_d = 1'b0;
      end else if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
         enfc_d = 1'b1;
      end

      base_d = start_acc ? base_addr : base_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         enfc_q       <= 1'b0;
         tag_vld_q    <= 1'b0;
         tag_region_q <= RG_X;
         tag_index_q  <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         enfc_q       <= enfc_d;
         tag_vld_q    <= issue;
         tag_region_q <= cur_region;
         tag_index_q  <= cur_index;
      end
   end

   // Read data arrives the cycle after issue, aligned with the in-flight tag.
   assign ram_addr  = base_q + issue_cnt;
   assign wr_en     = tag_vld_q;
   assign wr_region = tag_region_q;
   assign wr_index  = tag_index_q;
   assign wr_data   = tag_vld_q ? ram_rd_data : '0;
   assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign enFC      = enfc_q;

endmodule

// File: tb/tb_fc_dma_loader.sv
// Directed bench for fc_dma_loader with a scoreboard of expected bank writes.
module tb_fc_dma_loader;

   localparam int IP1 = 4;
   localparam int OP1 = 3;
   localparam int IP2 = 3;
   localparam int OP2 = 2;
   localparam int NW  = IP1 + OP1*IP1 + OP1 + OP2*IP2 + OP2;

   typedef struct {
      logic [2:0]  region;
      logic [3:0]  index;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] base_addr;
`ifdef FC_DMA_ABORT_EN
   logic        abort;
`endif
   logic        ram_rd_en;
   logic [15:0] ram_addr;
   logic        ram_gnt;
   logic [15:0] ram_rd_data = 16'h0;
   logic        wr_en;
   logic [2:0]  wr_region;
   logic [3:0]  wr_index;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        enFC;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_c = 0;
   int   gnt_mode = 0;
   int   lens[5];
   exp_t sb[$];

   fc_dma_loader #(
      .WORD_SIZE      (16),
      .ADDRESS_SIZE   (16),
      .IP_LAYER1_SIZE (IP1),
      .OP_LAYER1_SIZE (OP1),
      .IP_LAYER2_SIZE (IP2),
      .OP_LAYER2_SIZE (OP2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
`ifdef FC_DMA_ABORT_EN
      .abort       (abort),
`endif
      .ram_rd_en   (ram_rd_en),
      .ram_addr    (ram_addr),
      .ram_gnt     (ram_gnt),
      .ram_rd_data (ram_rd_data),
      .wr_en       (wr_en),
      .wr_region   (wr_region),
      .wr_index    (wr_index),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .enFC        (enFC)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: returns its own address as data, one cycle after a granted read.
   always @(posedge clk) if (ram_rd_en && ram_gnt) ram_rd_data <= ram_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && wr_en === 1'b1) begin
         check("write_expected", 32'(sb.size() != 0), 32'(1));
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wr_region", 32'(wr_region), 32'(e.region));
            check("wr_index",  32'(wr_index),  32'(e.index));
            check("wr_data",   32'(wr_data),   32'(e.data));
            check("wr_cycle",  32'(cyc),       32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      ram_gnt = (gnt_mode == 0) ? 1'b1 : (((cyc - start_c) % 2) == 1);
   endtask

   task automatic push_run(input logic [15:0] base, input int mode, input int nwords);
      exp_t e;
      int   k = 0;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < lens[r]; i++) begin
            if (k < nwords) begin
               e.region = 3'(r);
               e.index  = 4'(i);
               e.data   = base + 16'(k);
               e.cyc    = start_c + ((mode == 0) ? (k + 2) : (2*k + 2));
               sb.push_back(e);
            end
            k++;
         end
      end
   endtask

   task automatic begin_run(input logic [15:0] base, input int mode, input int nwords);
      base_addr = base;
      start     = 1'b1;
      start_c   = cyc;
      gnt_mode  = mode;
      push_run(base, mode, nwords);
      tick();
      start = 1'b0;
      check("c1_rd_en", 32'(ram_rd_en), 32'(1));
      check("c1_addr",  32'(ram_addr),  32'(base));
      check("c1_busy",  32'(busy),      32'(1));
      check("c1_enFC",  32'(enFC),      32'(0));
   endtask

   task automatic full_run(input logic [15:0] base, input int mode, input int poke, input int exp_done);
      int n;
      begin_run(base, mode, NW);
      n = 1;
      while (done !== 1'b1 && n < 200) begin
         if (n == poke) begin
            start     = 1'b1;
            base_addr = 16'h5555;
         end
         tick();
         start = 1'b0;
         n++;
      end
      check("done_cycle", 32'(n), 32'(exp_done));
      check("done_enFC",  32'(enFC), 32'(1));
      check("done_busy",  32'(busy), 32'(0));
      check("sb_drained", 32'(sb.size()), 32'(0));
      tick();
      check("post_done",  32'(done), 32'(0));
      check("post_enFC",  32'(enFC), 32'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      lens = '{IP1, OP1*IP1, OP1, OP2*IP2, OP2};
      reset     = 1'b0;
      start     = 1'b0;
      base_addr = 16'h0;
      ram_gnt   = 1'b1;
`ifdef FC_DMA_ABORT_EN
      abort     = 1'b0;
`endif
      repeat (2) tick();
      check("rst_rd_en",  32'(ram_rd_en), 32'(0));
      check("rst_addr",   32'(ram_addr),  32'(0));
      check("rst_wr_en",  32'(wr_en),     32'(0));
      check("rst_region", 32'(wr_region), 32'(0));
      check("rst_index",  32'(wr_index),  32'(0));
      check("rst_data",   32'(wr_data),   32'(0));
      check("rst_busy",   32'(busy),      32'(0));
      check("rst_done",   32'(done),      32'(0));
      check("rst_enFC",   32'(enFC),      32'(0));
      reset = 1'b1;
      tick();

      // Continuous grant with an ignored start during FETCH, then an immediate re-run.
      full_run(16'h0100, 0, 5, NW + 2);
      full_run(16'h0100, 0, -1, NW + 2);

      // Grant every other cycle.
      full_run(16'h0100, 1, -1, 55);

      // Address wrap past 0xFFFF.
      full_run(16'hFFF0, 0, -1, NW + 2);

      // Asynchronous reset right after write 10.
      begin_run(16'h0300, 0, NW);
      repeat (11) tick();
      #1 reset = 1'b0;
      #1;
      check("arst_wr_en",  32'(wr_en),     32'(0));
      check("arst_rd_en",  32'(ram_rd_en), 32'(0));
      check("arst_addr",   32'(ram_addr),  32'(0));
      check("arst_index",  32'(wr_index),  32'(0));
      check("arst_data",   32'(wr_data),   32'(0));
      check("arst_busy",   32'(busy),      32'(0));
      check("arst_enFC",   32'(enFC),      32'(0));
      sb.delete();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("arst_idle", 32'(busy), 32'(0));
      full_run(16'h0200, 0, -1, NW + 2);

`ifdef FC_DMA_ABORT_EN
      begin_run(16'h0400, 0, 7);
      repeat (7) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy",  32'(busy),      32'(0));
      check("abort_done",  32'(done),      32'(0));
      check("abort_enFC",  32'(enFC),      32'(0));
      check("abort_rd_en", 32'(ram_rd_en), 32'(0));
      repeat (5) begin
         tick();
         check("abort_nodone", 32'(done), 32'(0));
      end
      check("abort_sb", 32'(sb.size()), 32'(0));
`endif

      tick();
      check("final_sb", 32'(sb.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
